// File: rtl/file_register_pkg.sv
// Shared constants for the file register write path.
// FILE_REGISTER_CLEAR_EN enables the post-reset clear sequencer.
package file_register_pkg;

  localparam int FR_ADDR_W = 5;
  localparam int FR_DATA_W = 32;
  localparam int NUM_REGS  = 32;
  localparam int CLR_W     = $clog2(NUM_REGS);

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_REQ0 = 2'b01,
    GNT_REQ1 = 2'b10
  } grant_e;

endpackage

// File: rtl/file_register_write_arbiter_rr.sv
// Two-input round-robin arbiter; prio names the requester
// that wins when both are valid.
module rr_arbiter_2
  import file_register_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] ready,
  output logic [1:0] grant
);

  logic prio_q;
  logic prio_d;

  // ready is independent of the requester's own valid
  assign ready[0] = en & (~valid[1] | ~prio_q);
  assign ready[1] = en & (~valid[0] |  prio_q);
  assign grant    = valid & ready;

  always_comb begin
    prio_d = prio_q;
    unique case (1'b1)
      grant[0]: prio_d = 1'b1;
      grant[1]: prio_d = 1'b0;
      default:  prio_d = prio_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/file_register_write_arbiter.sv
// Shares the file register write port between two requesters.
// FILE_REGISTER_CLEAR_EN adds a zero-fill of all registers after reset.
module file_register_write_arbiter
  import file_register_pkg::*;
#(
  parameter int ADDR_W = FR_ADDR_W,
  parameter int DATA_W = FR_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              we,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic [CNT_W-1:0]  contention_cnt
);

  logic [1:0]        valid;
  logic [1:0]        ready;
  logic [1:0]        grant;
  logic              run;

  logic              we_q;
  logic              we_d;
  logic [ADDR_W-1:0] waddr_q;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  assign valid = {req1_valid, req0_valid};

`ifdef FILE_REGISTER_CLEAR_EN
  logic [0:0]       state_q;
  logic [0:0]       state_d;
  logic [CLR_W-1:0] clr_q;
  logic [CLR_W-1:0] clr_d;

  assign run  = (state_q == RUN) & ~rst_all;
  assign busy = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    if (state_q == CLEAR) begin
      clr_d = clr_q + CLR_W'(1);
      if (clr_q == CLR_W'(NUM_REGS - 1)) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end
`else
  assign run  = ~rst_all;
  assign busy = 1'b0;
`endif

  rr_arbiter_2 u_arb (
    .clk   (clk),
    .rst   (rst_all),
    .en    (run),
    .valid (valid),
    .ready (ready),
    .grant (grant)
  );

  assign req0_ready = ready[0];
  assign req1_ready = ready[1];

  always_comb begin
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef FILE_REGISTER_CLEAR_EN
    if (state_q == CLEAR) begin
      we_d    = 1'b1;
      waddr_d = ADDR_W'(clr_q);
      wdata_d = '0;
    end
`endif
    unique case (grant)
      GNT_REQ0: begin
        we_d    = 1'b1;
        waddr_d = req0_addr;
        wdata_d = req0_data;
      end
      GNT_REQ1: begin
        we_d    = 1'b1;
        waddr_d = req1_addr;
        wdata_d = req1_data;
      end
      default: begin
        we_d = we_d;
      end
    endcase
  end

  // Contended cycles only count while requests can be served
  always_comb begin
    cnt_d = cnt_q;
    if (run && (&valid) && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst_all) begin
    if (rst_all) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign we             = we_q;
  assign write_addr     = waddr_q;
  assign write_data     = wdata_q;
  assign contention_cnt = cnt_q;

endmodule
